// File: rtl/jt49_seq_pkg.sv
// jt49_seq_pkg: shared encodings for the jt49 command sequencer.
// Holds the opcode enum, FSM state constants, command-word field positions
// and a helper that splits a raw command word into its fields.
package jt49_seq_pkg;

  // Opcode field of a command word
  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_WAIT  = 2'b01,
    OP_END   = 2'b10,
    OP_JUMP  = 2'b11
  } op_t;

  // FSM state encodings (kept as plain constants so they can be probed as bits)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  // Command word field positions
  localparam int CHIP_HI = 15;
  localparam int CHIP_LO = 14;
  localparam int OP_HI   = 13;
  localparam int OP_LO   = 12;
  localparam int ARG_HI  = 11;
  localparam int ARG_LO  = 0;

  // Sub-fields of the 12-bit argument: register / loop count, and data / target
  localparam int SEL_HI  = 11;
  localparam int SEL_LO  = 8;
  localparam int BYTE_HI = 7;
  localparam int BYTE_LO = 0;

  typedef struct packed {
    logic [1:0]  chip;
    op_t         op;
    logic [11:0] arg;
  } cmd_t;

  // Split a raw 16-bit command word into chip / op / argument
  function automatic cmd_t unpack_cmd(input logic [15:0] word);
    cmd_t c;
    c.chip = word[CHIP_HI:CHIP_LO];
    c.op   = op_t'(word[OP_HI:OP_LO]);
    c.arg  = word[ARG_HI:ARG_LO];
    return c;
  endfunction

endpackage

// File: rtl/jt49_seq_ram.sv
// jt49_seq_ram: DEPTH x 16 command store, one write port and one
// synchronous read port with a single cycle of read latency.
module jt49_seq_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  logic [15:0] mem [DEPTH];

  // Write port: contents are never reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/jt49_seq.sv
// jt49_seq: replays a stored list of PSG register writes, waits, jumps and
// bounded loops onto the CPU-side write bus of one or more jt49 chips.
// Each command takes a FETCH cycle (RAM address = pc) and an EXEC cycle
// (decode of the RAM output); a WRITE strobe appears in the cycle after EXEC.
module jt49_seq
  import jt49_seq_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int CHIPS      = 1,
  parameter int WAIT_SHIFT = 11,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  input  logic             ld_we,
  input  logic [AW-1:0]    ld_addr,
  input  logic [15:0]      ld_data,
  output logic [3:0]       psg_addr,
  output logic [7:0]       psg_din,
  output logic             psg_wr_n,
  output logic [CHIPS-1:0] psg_cs_n,
  output logic [1:0]       dbg_state
);

  localparam int CW = 12 + WAIT_SHIFT;

  logic [1:0]    state;
  logic [AW-1:0] pc;
  logic          armed;
  logic [3:0]    loop_cnt;
  logic [CW-1:0] wait_cnt;
  logic [15:0]   rd_data;
  logic          ram_we;

  // The store only accepts loads while the sequencer is parked
  assign ram_we    = ld_we && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  jt49_seq_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr (pc),
    .rd_data (rd_data)
  );

  cmd_t       cmd;
  logic [3:0] cmd_sel;
  logic [7:0] cmd_byte;

  assign cmd      = unpack_cmd(rd_data);
  assign cmd_sel  = cmd.arg[SEL_HI:SEL_LO];
  assign cmd_byte = cmd.arg[BYTE_HI:BYTE_LO];

  // Chip decode: one-hot active-low select, or no strobe for a chip that does not exist
  logic             chip_ok;
  logic [CHIPS-1:0] cs_sel;

  always_comb begin
    chip_ok = int'(cmd.chip) < CHIPS;
    cs_sel  = '1;
    for (int i = 0; i < CHIPS; i++) begin
      if (int'(cmd.chip) == i) cs_sel[i] = 1'b0;
    end
  end

  // Wait length: the WAIT command's own fetch/exec slot and the following
  // fetch/exec are absorbed into arg<<WAIT_SHIFT, so the counter is loaded
  // with the remainder (never below one cycle).
  logic [CW-1:0] wait_len;
  logic [CW-1:0] wait_load;

  always_comb begin
    wait_len  = CW'(cmd.arg) << WAIT_SHIFT;
    wait_load = (wait_len > CW'(2)) ? (wait_len - CW'(2)) : CW'(1);
  end

  // Loop bookkeeping for JUMP: R=0 always jumps, otherwise the body runs R+1 times
  logic       jump_take;
  logic       armed_nxt;
  logic [3:0] loop_nxt;

  always_comb begin
    jump_take = 1'b0;
    armed_nxt = armed;
    loop_nxt  = loop_cnt;
    if (cmd_sel == 4'd0) begin
      jump_take = 1'b1;
    end else if (!armed) begin
      armed_nxt = 1'b1;
      loop_nxt  = cmd_sel - 4'd1;
      jump_take = 1'b1;
    end else if (loop_cnt != 4'd0) begin
      loop_nxt  = loop_cnt - 4'd1;
      jump_take = 1'b1;
    end else begin
      armed_nxt = 1'b0;
    end
  end

  // Next-state decode; stop overrides everything and lands in IDLE
  logic [1:0] state_nxt;

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_FETCH;
        ST_FETCH: state_nxt = ST_EXEC;
        ST_EXEC: begin
          case (cmd.op)
            OP_WRITE: state_nxt = ST_FETCH;
            OP_WAIT:  state_nxt = (cmd.arg == 12'd0) ? ST_FETCH : ST_WAIT;
            OP_END:   state_nxt = ST_IDLE;
            OP_JUMP:  state_nxt = ST_FETCH;
            default:  state_nxt = ST_IDLE;
          endcase
        end
        ST_WAIT:  if (wait_cnt == CW'(1)) state_nxt = ST_FETCH;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Program counter, loop flag/count and wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= '0;
      armed    <= 1'b0;
      loop_cnt <= '0;
      wait_cnt <= '0;
    end else if (!stop) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc       <= '0;
            armed    <= 1'b0;
            loop_cnt <= '0;
          end
        end
        ST_EXEC: begin
          pc <= pc + AW'(1);
          if (cmd.op == OP_WAIT) wait_cnt <= wait_load;
          if (cmd.op == OP_JUMP) begin
            armed    <= armed_nxt;
            loop_cnt <= loop_nxt;
            if (jump_take) pc <= cmd_byte[AW-1:0];
          end
        end
        ST_WAIT: wait_cnt <= wait_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // PSG bus and done pulse: strobe and done last one cycle, address/data hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done     <= 1'b0;
      psg_wr_n <= 1'b1;
      psg_cs_n <= '1;
      psg_addr <= '0;
      psg_din  <= '0;
    end else begin
      done     <= 1'b0;
      psg_wr_n <= 1'b1;
      psg_cs_n <= '1;
      if (!stop && state == ST_EXEC) begin
        if (cmd.op == OP_WRITE && chip_ok) begin
          psg_wr_n <= 1'b0;
          psg_cs_n <= cs_sel;
          psg_addr <= cmd_sel;
          psg_din  <= cmd_byte;
        end
        if (cmd.op == OP_END) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jt49_seq.sv
// tb_jt49_seq: directed programs for the jt49 command sequencer. Drivers
// push expected strobes (cycle, chip selects, reg, data) and done cycles into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_jt49_seq;

  localparam int DEPTH = 16;
  localparam int CHIPS = 2;
  localparam int WS    = 11;
  localparam int AW    = $clog2(DEPTH);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             busy;
  logic             done;
  logic             ld_we;
  logic [AW-1:0]    ld_addr;
  logic [15:0]      ld_data;
  logic [3:0]       psg_addr;
  logic [7:0]       psg_din;
  logic             psg_wr_n;
  logic [CHIPS-1:0] psg_cs_n;
  logic [1:0]       dbg_state;

  jt49_seq #(
    .DEPTH      (DEPTH),
    .CHIPS      (CHIPS),
    .WAIT_SHIFT (WS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .done      (done),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .psg_addr  (psg_addr),
    .psg_din   (psg_din),
    .psg_wr_n  (psg_wr_n),
    .psg_cs_n  (psg_cs_n),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic mon_on = 1'b0;
  logic [45:0] strobe_q[$];  // {cycle, cs_n, addr, din}
  logic [31:0] done_q[$];    // cycle of done pulse

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [45:0] strobe_item(input int c, input logic [1:0] cs,
                                              input logic [3:0] a, input logic [7:0] d);
    return {c[31:0], cs, a, d};
  endfunction

  // Monitor: compare every strobe and done pulse against the queues
  always @(negedge clk) begin
    if (mon_on) begin
      if (psg_wr_n == 1'b0) begin
        if (strobe_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL strobe_unexpected: got cs_n=%b addr=%0h din=%0h at cycle %0d, expected none",
                   psg_cs_n, psg_addr, psg_din, cyc);
        end else begin
          check("strobe", {cyc[31:0], psg_cs_n, psg_addr, psg_din}, strobe_q.pop_front());
        end
      end else begin
        check("cs_idle", psg_cs_n, 2'b11);
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
          check("done_busy", busy, 1'b0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic load_word(input int a, input logic [15:0] w);
    ld_we   = 1'b1;
    ld_addr = AW'(a);
    ld_data = w;
    step(1);
    ld_we   = 1'b0;
  endtask

  task automatic do_start(output int s);
    start = 1'b1;
    s     = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_strobes_left"}, strobe_q.size(), 0);
    check({tag, "_done_left"}, done_q.size(), 0);
    strobe_q.delete();
    done_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    ld_we   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    step(3);

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wr_n", psg_wr_n, 1'b1);
    check("rst_cs_n", psg_cs_n, 2'b11);
    check("rst_addr", psg_addr, 4'h0);
    check("rst_din", psg_din, 8'h00);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    step(1);

    // Two back-to-back writes then END
    load_word(0, 16'h0001);
    load_word(1, 16'h0100);
    load_word(2, 16'h2000);
    do_start(s);
    strobe_q.push_back(strobe_item(s + 3, 2'b10, 4'h0, 8'h01));
    strobe_q.push_back(strobe_item(s + 5, 2'b10, 4'h1, 8'h00));
    done_q.push_back(s + 7);
    check("t1_busy_after_start", busy, 1'b1);
    run_until(s + 12);
    check("t1_busy_end", busy, 1'b0);
    check_drained("t1");

    // WAIT 1 with WAIT_SHIFT 11: strobes 2050 cycles apart
    load_word(0, 16'h0810);
    load_word(1, 16'h1001);
    load_word(2, 16'h080F);
    load_word(3, 16'h2000);
    do_start(s);
    strobe_q.push_back(strobe_item(s + 3, 2'b10, 4'h8, 8'h10));
    strobe_q.push_back(strobe_item(s + 2053, 2'b10, 4'h8, 8'h0F));
    done_q.push_back(s + 2055);
    run_until(s + 1000);
    check("t2_busy_in_wait", busy, 1'b1);
    run_until(s + 2060);
    check_drained("t2");

    // Bounded loop R=2: three strobes, twice (armed cleared by start)
    load_word(0, 16'h0731);
    load_word(1, 16'h3200);
    load_word(2, 16'h2000);
    for (int rep = 0; rep < 2; rep++) begin
      do_start(s);
      strobe_q.push_back(strobe_item(s + 3, 2'b10, 4'h7, 8'h31));
      strobe_q.push_back(strobe_item(s + 7, 2'b10, 4'h7, 8'h31));
      strobe_q.push_back(strobe_item(s + 11, 2'b10, 4'h7, 8'h31));
      done_q.push_back(s + 15);
      run_until(s + 20);
      check_drained("t3");
    end

    // Chip addressing: chip1 selects cs_n=01, chip3 is a silent slot
    load_word(0, 16'h4255);
    load_word(1, 16'hC3AA);
    load_word(2, 16'h0466);
    load_word(3, 16'h2000);
    do_start(s);
    strobe_q.push_back(strobe_item(s + 3, 2'b01, 4'h2, 8'h55));
    strobe_q.push_back(strobe_item(s + 7, 2'b10, 4'h4, 8'h66));
    done_q.push_back(s + 9);
    run_until(s + 5);
    check("t4_addr_hold", psg_addr, 4'h2);
    check("t4_din_hold", psg_din, 8'h55);
    check("t4_chip3_no_strobe", psg_wr_n, 1'b1);
    run_until(s + 14);
    check_drained("t4");

    // Stop mid-WAIT inside an endless loop; load while busy is ignored
    load_word(0, 16'h0011);
    load_word(1, 16'h1001);
    load_word(2, 16'h3000);
    do_start(s);
    strobe_q.push_back(strobe_item(s + 3, 2'b10, 4'h0, 8'h11));
    run_until(s + 50);
    load_word(0, 16'h0722);
    run_until(s + 100);
    do_stop();
    check("t5_busy_after_stop", busy, 1'b0);
    check("t5_wr_n_after_stop", psg_wr_n, 1'b1);
    run_until(s + 3000);
    check("t5_still_idle", busy, 1'b0);
    check_drained("t5a");
    do_start(s);
    strobe_q.push_back(strobe_item(s + 3, 2'b10, 4'h0, 8'h11));
    run_until(s + 10);
    do_stop();
    check("t5_busy_after_stop2", busy, 1'b0);
    run_until(s + 3000);
    check_drained("t5b");

    // Stop during EXEC of a WRITE cancels the pending strobe
    do_start(s);
    run_until(s + 2);
    do_stop();
    check("t5_cancel_wr_n", psg_wr_n, 1'b1);
    check("t5_cancel_busy", busy, 1'b0);
    step(4);
    check_drained("t5c");

    // start and stop together: stop wins
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    check("t5_stop_beats_start", busy, 1'b0);
    step(4);
    check_drained("t5d");

    // Reset asserted during a strobe cycle
    load_word(0, 16'h0577);
    load_word(1, 16'h2000);
    do_start(s);
    strobe_q.push_back(strobe_item(s + 3, 2'b10, 4'h5, 8'h77));
    run_until(s + 3);
    rst_n = 1'b0;
    step(1);
    check("t6_wr_n", psg_wr_n, 1'b1);
    check("t6_cs_n", psg_cs_n, 2'b11);
    check("t6_busy", busy, 1'b0);
    check("t6_addr", psg_addr, 4'h0);
    rst_n = 1'b1;
    step(10);
    check_drained("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
